// File: rtl/bus_sequencer_pkg.sv
// Shared constants for the basic-computer bus sequencer.
// Bus-select codes, ALU op encodings, opcodes and the HLT word.
package bus_sequencer_pkg;

  typedef enum logic [2:0] {
    BUS_NONE = 3'd0,
    BUS_AR   = 3'd1,
    BUS_PC   = 3'd2,
    BUS_DR   = 3'd3,
    BUS_AC   = 3'd4,
    BUS_IR   = 3'd5,
    BUS_TR   = 3'd6,
    BUS_MEM  = 3'd7
  } bus_sel_e;

  typedef enum logic [1:0] {
    ALU_AND  = 2'd0,
    ALU_ADD  = 2'd1,
    ALU_PASS = 2'd2
  } alu_op_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_REG = 3'd7;

  localparam logic [15:0] HLT_WORD = 16'h7001;

endpackage

// File: rtl/bus_sequencer_seq_timer.sv
// Sequence counter with clear/increment and one-hot T-state decode.
// Reset returns the counter to T0.
module seq_timer #(
  parameter int SC_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [SC_W-1:0]      sc_o,
  output logic [(1<<SC_W)-1:0] t_o
);

  localparam int NT = 1 << SC_W;

  logic [SC_W-1:0] sc_q, sc_d;

  // Clear wins over increment; otherwise hold.
  always_comb begin
    sc_d = sc_q;
    if (clr_i) begin
      sc_d = '0;
    end else if (inc_i) begin
      sc_d = sc_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  assign sc_o = sc_q;
  assign t_o  = NT'(1) << sc_q;

endmodule

// File: rtl/bus_sequencer.sv
// Timing/control sequencer for the 16-bit common-bus basic computer.
// Optional interrupt cycle: define BUS_SEQUENCER_INTR_EN.
module bus_sequencer
  import bus_sequencer_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SC_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] ir,
  input  logic             dr_zero,
  input  logic             intr_req,
  output logic [2:0]       bus_sel,
  output logic             ar_ld,
  output logic             ar_inc,
  output logic             ar_clr,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             pc_clr,
  output logic             dr_ld,
  output logic             dr_inc,
  output logic             ir_ld,
  output logic             tr_ld,
  output logic             ac_ld,
  output logic [1:0]       alu_op,
  output logic             mem_wr,
  output logic             rr_exec,
  output logic             ien_clr,
  output logic             running,
  output logic [SC_W-1:0]  sc
);

  localparam int NT = 1 << SC_W;

  logic          running_q, running_d;
  logic [2:0]    d_q, d_d;
  logic          i_q, i_d;
  logic          sc_clr, sc_inc;
  logic [NT-1:0] t;
  logic          intr_cyc;

`ifdef BUS_SEQUENCER_INTR_EN
  logic r_q, r_d;
  assign intr_cyc = r_q;
`else
  logic intr_req_unused;
  assign intr_req_unused = intr_req;
  assign intr_cyc = 1'b0;
`endif

  seq_timer #(.SC_W(SC_W)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (sc_clr),
    .inc_i (sc_inc),
    .sc_o  (sc),
    .t_o   (t)
  );

  // Strobe decode and next-state for run flag, opcode and R.
  always_comb begin
    bus_sel   = BUS_NONE;
    ar_ld     = 1'b0;
    ar_inc    = 1'b0;
    ar_clr    = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_clr    = 1'b0;
    dr_ld     = 1'b0;
    dr_inc    = 1'b0;
    ir_ld     = 1'b0;
    tr_ld     = 1'b0;
    ac_ld     = 1'b0;
    alu_op    = ALU_AND;
    mem_wr    = 1'b0;
    rr_exec   = 1'b0;
    ien_clr   = 1'b0;
    sc_clr    = 1'b0;
    running_d = running_q;
    d_d       = d_q;
    i_d       = i_q;
`ifdef BUS_SEQUENCER_INTR_EN
    r_d       = r_q;
`endif
    if (!running_q) begin
      if (start) begin
        running_d = 1'b1;
      end
    end else if (intr_cyc) begin
      unique case (1'b1)
        t[0]: begin
          bus_sel = BUS_PC;
          tr_ld   = 1'b1;
          ar_clr  = 1'b1;
        end
        t[1]: begin
          bus_sel = BUS_TR;
          mem_wr  = 1'b1;
          pc_clr  = 1'b1;
        end
        t[2]: begin
          pc_inc  = 1'b1;
          ien_clr = 1'b1;
          sc_clr  = 1'b1;
`ifdef BUS_SEQUENCER_INTR_EN
          r_d     = 1'b0;
`endif
        end
        default: sc_clr = 1'b1;
      endcase
    end else begin
      unique case (1'b1)
        t[0]: begin
          bus_sel = BUS_PC;
          ar_ld   = 1'b1;
        end
        t[1]: begin
          bus_sel = BUS_MEM;
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
        end
        t[2]: begin
          bus_sel = BUS_IR;
          ar_ld   = 1'b1;
          d_d     = ir[WIDTH-2 -: 3];
          i_d     = ir[WIDTH-1];
        end
        t[3]: begin
          if (d_q == OP_REG) begin
            sc_clr = 1'b1;
            if (ir == WIDTH'(HLT_WORD)) begin
              running_d = 1'b0;
            end else begin
              rr_exec = 1'b1;
            end
          end else if (i_q) begin
            bus_sel = BUS_MEM;
            ar_ld   = 1'b1;
          end
        end
        t[4]: begin
          case (d_q)
            OP_AND, OP_ADD, OP_LDA, OP_ISZ: begin
              bus_sel = BUS_MEM;
              dr_ld   = 1'b1;
            end
            OP_STA: begin
              bus_sel = BUS_AC;
              mem_wr  = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BUN: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_BSA: begin
              bus_sel = BUS_PC;
              mem_wr  = 1'b1;
              ar_inc  = 1'b1;
            end
            default: sc_clr = 1'b1;
          endcase
        end
        t[5]: begin
          case (d_q)
            OP_AND, OP_ADD, OP_LDA: begin
              ac_ld  = 1'b1;
              sc_clr = 1'b1;
              alu_op = (d_q == OP_AND) ? ALU_AND :
                       (d_q == OP_ADD) ? ALU_ADD : ALU_PASS;
            end
            OP_BSA: begin
              bus_sel = BUS_AR;
              pc_ld   = 1'b1;
              sc_clr  = 1'b1;
            end
            OP_ISZ: dr_inc = 1'b1;
            default: sc_clr = 1'b1;
          endcase
        end
        t[6]: begin
          // T6 always ends the instruction so SC never passes 6.
          sc_clr = 1'b1;
          if (d_q == OP_ISZ) begin
            bus_sel = BUS_DR;
            mem_wr  = 1'b1;
            pc_inc  = dr_zero;
          end
        end
        default: sc_clr = 1'b1;
      endcase
    end
`ifdef BUS_SEQUENCER_INTR_EN
    // Enter the interrupt cycle whenever an instruction ends.
    if (running_q && running_d && sc_clr && !r_q && intr_req) begin
      r_d = 1'b1;
    end
`endif
  end

  assign sc_inc  = running_q & ~sc_clr;
  assign running = running_q;

  // Run flag and latched opcode/indirect bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running_q <= 1'b0;
      d_q       <= 3'd0;
      i_q       <= 1'b0;
    end else begin
      running_q <= running_d;
      d_q       <= d_d;
      i_q       <= i_d;
    end
  end

`ifdef BUS_SEQUENCER_INTR_EN
  // Interrupt-cycle flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else begin
      r_q <= r_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_sequencer.sv
// Table-driven bench for bus_sequencer.
// Interrupt vectors are added when BUS_SEQUENCER_INTR_EN is defined.
module tb_bus_sequencer;

  localparam logic [13:0] ARLD   = 14'h2000;
  localparam logic [13:0] ARINC  = 14'h1000;
  localparam logic [13:0] ARCLR  = 14'h0800;
  localparam logic [13:0] PCLD   = 14'h0400;
  localparam logic [13:0] PCINC  = 14'h0200;
  localparam logic [13:0] PCCLR  = 14'h0100;
  localparam logic [13:0] DRLD   = 14'h0080;
  localparam logic [13:0] DRINC  = 14'h0040;
  localparam logic [13:0] IRLD   = 14'h0020;
  localparam logic [13:0] TRLD   = 14'h0010;
  localparam logic [13:0] ACLD   = 14'h0008;
  localparam logic [13:0] MEMWR  = 14'h0004;
  localparam logic [13:0] RREX   = 14'h0002;
  localparam logic [13:0] IENCLR = 14'h0001;

  typedef struct {
    logic        start;
    logic [15:0] ir;
    logic        dz;
    logic        intr;
    logic        run;
    logic [3:0]  sc;
    logic [2:0]  bus;
    logic [13:0] strb;
    logic [1:0]  alu;
  } vec_t;

  logic        clk, rst_n, start, dr_zero, intr_req;
  logic [15:0] ir;
  logic [2:0]  bus_sel;
  logic        ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr;
  logic        dr_ld, dr_inc, ir_ld, tr_ld, ac_ld;
  logic [1:0]  alu_op;
  logic        mem_wr, rr_exec, ien_clr, running;
  logic [3:0]  sc;

  int errors = 0;
  int checks = 0;
  vec_t vq[$];

  bus_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ir       (ir),
    .dr_zero  (dr_zero),
    .intr_req (intr_req),
    .bus_sel  (bus_sel),
    .ar_ld    (ar_ld),
    .ar_inc   (ar_inc),
    .ar_clr   (ar_clr),
    .pc_ld    (pc_ld),
    .pc_inc   (pc_inc),
    .pc_clr   (pc_clr),
    .dr_ld    (dr_ld),
    .dr_inc   (dr_inc),
    .ir_ld    (ir_ld),
    .tr_ld    (tr_ld),
    .ac_ld    (ac_ld),
    .alu_op   (alu_op),
    .mem_wr   (mem_wr),
    .rr_exec  (rr_exec),
    .ien_clr  (ien_clr),
    .running  (running),
    .sc       (sc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic st, logic [15:0] i, logic dz,
                              logic it, logic r, logic [3:0] s,
                              logic [2:0] b, logic [13:0] m,
                              logic [1:0] a);
    vec_t v;
    v.start = st; v.ir = i; v.dz = dz; v.intr = it;
    v.run = r; v.sc = s; v.bus = b; v.strb = m; v.alu = a;
    return v;
  endfunction

  function automatic void add(logic st, logic [15:0] i, logic dz,
                              logic it, logic r, logic [3:0] s,
                              logic [2:0] b, logic [13:0] m,
                              logic [1:0] a);
    vq.push_back(mk(st, i, dz, it, r, s, b, m, a));
  endfunction

  function automatic void fetch(logic [15:0] i, logic it, logic st1);
    add(0, i, 0, it, 1, 0, 2, ARLD, 0);
    add(st1, i, 0, it, 1, 1, 7, IRLD | PCINC, 0);
    add(0, i, 0, it, 1, 2, 5, ARLD, 0);
  endfunction

  task automatic chk(string nm, vec_t v);
    logic [13:0] act;
    act = {ar_ld, ar_inc, ar_clr, pc_ld, pc_inc, pc_clr, dr_ld,
           dr_inc, ir_ld, tr_ld, ac_ld, mem_wr, rr_exec, ien_clr};
    checks++;
    if (running !== v.run || sc !== v.sc || bus_sel !== v.bus ||
        act !== v.strb || alu_op !== v.alu) begin
      errors++;
      $display("FAIL %s: got run=%b sc=%0d bus=%0d strb=%h alu=%0d want run=%b sc=%0d bus=%0d strb=%h alu=%0d",
               nm, running, sc, bus_sel, act, alu_op,
               v.run, v.sc, v.bus, v.strb, v.alu);
    end
  endtask

  task automatic apply(vec_t v, string nm);
    start    = v.start;
    ir       = v.ir;
    dr_zero  = v.dz;
    intr_req = v.intr;
    #1;
    chk(nm, v);
  endtask

  task automatic build();
    add(1, 16'h0000, 0, 0, 0, 0, 0, 0, 0);
    // LDA direct
    fetch(16'h2005, 0, 0);
    add(0, 16'h2005, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h2005, 0, 0, 1, 4, 7, DRLD, 0);
    add(0, 16'h2005, 0, 0, 1, 5, 0, ACLD, 2);
    // ADD indirect, start during T1 ignored
    fetch(16'h9020, 0, 1);
    add(0, 16'h9020, 0, 0, 1, 3, 7, ARLD, 0);
    add(0, 16'h9020, 0, 0, 1, 4, 7, DRLD, 0);
    add(0, 16'h9020, 0, 0, 1, 5, 0, ACLD, 1);
    // BSA
    fetch(16'h5010, 0, 0);
    add(0, 16'h5010, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h5010, 0, 0, 1, 4, 2, MEMWR | ARINC, 0);
    add(0, 16'h5010, 0, 0, 1, 5, 1, PCLD, 0);
    // ISZ, DR reaches zero
    fetch(16'h6030, 0, 0);
    add(0, 16'h6030, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h6030, 0, 0, 1, 4, 7, DRLD, 0);
    add(0, 16'h6030, 0, 0, 1, 5, 0, DRINC, 0);
    add(0, 16'h6030, 1, 0, 1, 6, 3, MEMWR | PCINC, 0);
    // ISZ, DR nonzero
    fetch(16'h6030, 0, 0);
    add(0, 16'h6030, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h6030, 0, 0, 1, 4, 7, DRLD, 0);
    add(0, 16'h6030, 0, 0, 1, 5, 0, DRINC, 0);
    add(0, 16'h6030, 0, 0, 1, 6, 3, MEMWR, 0);
    // STA
    fetch(16'h3000, 0, 0);
    add(0, 16'h3000, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h3000, 0, 0, 1, 4, 4, MEMWR, 0);
    // BUN
    fetch(16'h4000, 0, 0);
    add(0, 16'h4000, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h4000, 0, 0, 1, 4, 1, PCLD, 0);
    // AND
    fetch(16'h0000, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h0000, 0, 0, 1, 4, 7, DRLD, 0);
    add(0, 16'h0000, 0, 0, 1, 5, 0, ACLD, 0);
    // register-reference
    fetch(16'h7800, 0, 0);
    add(0, 16'h7800, 0, 0, 1, 3, 0, RREX, 0);
    // HLT, then idle until start
    fetch(16'h7001, 0, 0);
    add(0, 16'h7001, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h7001, 0, 0, 0, 0, 0, 0, 0);
    add(0, 16'h7001, 0, 0, 0, 0, 0, 0, 0);
    add(1, 16'h7001, 0, 0, 0, 0, 0, 0, 0);
    fetch(16'h4000, 0, 0);
    add(0, 16'h4000, 0, 0, 1, 3, 0, 0, 0);
    add(0, 16'h4000, 0, 0, 1, 4, 1, PCLD, 0);
`ifdef BUS_SEQUENCER_INTR_EN
    // STA with pending interrupt, then RT0..RT2, then T0
    fetch(16'h3000, 1, 0);
    add(0, 16'h3000, 0, 1, 1, 3, 0, 0, 0);
    add(0, 16'h3000, 0, 1, 1, 4, 4, MEMWR, 0);
    add(0, 16'h3000, 0, 0, 1, 0, 2, TRLD | ARCLR, 0);
    add(0, 16'h3000, 0, 0, 1, 1, 6, MEMWR | PCCLR, 0);
    add(0, 16'h3000, 0, 0, 1, 2, 0, PCINC | IENCLR, 0);
    add(0, 16'h3000, 0, 0, 1, 0, 2, ARLD, 0);
`endif
  endtask

  initial begin
    vec_t zero_v;
    rst_n = 1'b0; start = 1'b0; ir = '0;
    dr_zero = 1'b0; intr_req = 1'b0;
    zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    build();
    #2;
    chk("reset", zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (vq[i]) begin
      apply(vq[i], $sformatf("vec%0d", i));
      @(negedge clk);
    end
    // Async reset in the middle of LDA T4.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(1, 16'h2005, 0, 0, 0, 0, 0, 0, 0), "mid_start");
    @(negedge clk);
    apply(mk(0, 16'h2005, 0, 0, 1, 0, 2, ARLD, 0), "mid_t0");
    @(negedge clk);
    apply(mk(0, 16'h2005, 0, 0, 1, 1, 7, IRLD | PCINC, 0), "mid_t1");
    @(negedge clk);
    apply(mk(0, 16'h2005, 0, 0, 1, 2, 5, ARLD, 0), "mid_t2");
    @(negedge clk);
    apply(mk(0, 16'h2005, 0, 0, 1, 3, 0, 0, 0), "mid_t3");
    @(negedge clk);
    apply(mk(0, 16'h2005, 0, 0, 1, 4, 7, DRLD, 0), "mid_t4");
    rst_n = 1'b0;
    #1;
    chk("rst_t4", zero_v);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst0", zero_v);
    @(negedge clk);
    #1;
    chk("post_rst1", zero_v);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
